// File: rtl/stopwatch_bcd.sv
// rtl/stopwatch_bcd.sv - MM:SS.hh BCD stopwatch with debounced start/clear/lap buttons
//
// Parameters:
//   TICK_DIV  clk cycles per 1/100 s tick
//   DB_CYC    consecutive stable cycles needed to accept a button level change
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   btn_start  raw run/pause toggle button (async, active-high)
//   btn_clear  raw clear button (async, active-high)
//   btn_lap    raw lap freeze/unfreeze button (async, active-high)
//   num0..num5 registered BCD digits: hundredths, tenths, sec units, sec tens, min units, min tens
//   dp_out     registered decimal-point enables, one bit per digit index
//   running    registered, high in RUN and LAP
// Build option:
//   STOPWATCH_SATURATE_EN  when defined, a tick at 59:59.99 holds the count and pauses
//                          instead of wrapping to 00:00.00

module stopwatch_bcd #(
    parameter int TICK_DIV = 500000,
    parameter int DB_CYC   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic [3:0] num5,
    output logic [5:0] dp_out,
    output logic       running
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_LAP   = 2'd3;

    // Button index: 0 = start, 1 = clear, 2 = lap
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      db_q;
    logic [2:0]      db_prev_q;
    logic [2:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [3];

    assign btn_raw = {btn_lap, btn_clear, btn_start};

    // Synchronize, debounce, then register a one-cycle pulse on each accepted rising level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_W'(DB_CYC - 1)) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // BCD increment across all six digits; the tens digits of seconds and minutes roll at 5.
    function automatic logic [23:0] bcd_inc(input logic [23:0] c);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  lim;
        logic [3:0]  d;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            d   = c[i*4 +: 4];
            if (carry) begin
                if (d == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [23:0]      cnt_q, cnt_d;
    logic [23:0]      snap_q, snap_d;
    logic [23:0]      disp_q, disp_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [5:0]       dp_q, dp_d;
    logic             running_q, running_d;

    logic run_now;
    logic tick;
    logic pr_start;
    logic pr_clear;
    logic pr_lap;

    always_comb begin
        run_now = (state_q == S_RUN) || (state_q == S_LAP);
        tick    = run_now && (presc_q == PRE_W'(TICK_DIV - 1));

        // Only the highest-priority press is considered; the rest are dropped.
        pr_clear = press_q[1];
        pr_start = press_q[0] & ~press_q[1];
        pr_lap   = press_q[2] & ~press_q[1] & ~press_q[0];

        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        presc_d = presc_q;

        if (run_now) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        if (tick) begin
            cnt_d = bcd_inc(cnt_q);
        end

        case (state_q)
            S_IDLE: begin
                if (pr_start) state_d = S_RUN;
            end
            S_RUN: begin
                if (pr_start) begin
                    state_d = S_PAUSE;
                end else if (pr_lap) begin
                    state_d = S_LAP;
                    snap_d  = cnt_q;   // pre-tick value if a tick lands on this edge
                end
            end
            S_PAUSE: begin
                if (pr_clear) begin
                    state_d = S_IDLE;
                end else if (pr_start) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (pr_lap) state_d = S_RUN;
            end
        endcase

`ifdef STOPWATCH_SATURATE_EN
        if (tick && (cnt_q == 24'h595999)) begin
            cnt_d   = cnt_q;
            state_d = S_PAUSE;
        end
`endif

        if (state_d == S_IDLE) begin
            cnt_d   = '0;
            presc_d = '0;
        end

        running_d = (state_d == S_RUN) || (state_d == S_LAP);
        disp_d    = (state_d == S_LAP) ? snap_d : cnt_d;
        // Point after seconds units is fixed; the one after minutes units blinks at 1 Hz.
        dp_d      = {1'b0, running_d & (cnt_d[7:4] < 4'd5), 1'b0, 1'b1, 2'b00};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            snap_q    <= '0;
            disp_q    <= '0;
            presc_q   <= '0;
            dp_q      <= 6'b000100;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            disp_q    <= disp_d;
            presc_q   <= presc_d;
            dp_q      <= dp_d;
            running_q <= running_d;
        end
    end

    assign num0    = disp_q[3:0];
    assign num1    = disp_q[7:4];
    assign num2    = disp_q[11:8];
    assign num3    = disp_q[15:12];
    assign num4    = disp_q[19:16];
    assign num5    = disp_q[23:20];
    assign dp_out  = dp_q;
    assign running = running_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb/tb_stopwatch_bcd.sv - self-checking bench for stopwatch_bcd (TICK_DIV=4, DB_CYC=3)

module tb_stopwatch_bcd;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic [3:0] num0, num1, num2, num3, num4, num5;
    logic [5:0] dp_out;
    logic       running;

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [2:0] B_START = 3'b001;
    localparam logic [2:0] B_CLEAR = 3'b010;
    localparam logic [2:0] B_LAP   = 3'b100;

    stopwatch_bcd #(.TICK_DIV(4), .DB_CYC(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .num0      (num0),
        .num1      (num1),
        .num2      (num2),
        .num3      (num3),
        .num4      (num4),
        .num5      (num5),
        .dp_out    (dp_out),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  btn;
        int          wait_cyc;
        logic [23:0] num;
        logic [5:0]  dp;
        logic        run;
    } vec_t;

    vec_t vecs [10];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [2:0] m);
        btn_start = m[0];
        btn_clear = m[1];
        btn_lap   = m[2];
    endtask

    // Hold for 10 cycles, then release and let the release debounce settle (16 edges total).
    task automatic press(input logic [2:0] m);
        set_btn(m);
        step(10);
        set_btn(3'b000);
        step(6);
    endtask

    task automatic check(input string name, input logic [23:0] en, input logic [5:0] ed,
                         input logic er);
        logic [23:0] an;
        an = {num5, num4, num3, num2, num1, num0};
        total++;
        if (an === en) pass_cnt++;
        else $display("FAIL %s num: got %h want %h", name, an, en);
        total++;
        if (dp_out === ed) pass_cnt++;
        else $display("FAIL %s dp_out: got %b want %b", name, dp_out, ed);
        total++;
        if (running === er) pass_cnt++;
        else $display("FAIL %s running: got %b want %b", name, running, er);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].btn != 3'b000) press(vecs[i].btn);
            if (vecs[i].wait_cyc > 0) step(vecs[i].wait_cyc);
            check($sformatf("vec%0d", i), vecs[i].num, vecs[i].dp, vecs[i].run);
        end
    endtask

    initial begin
        // count = (running edges since clear) / 4
        vecs[0] = '{3'b000,  211, 24'h000055, 6'b000100, 1'b1};
        vecs[1] = '{3'b000,  180, 24'h000100, 6'b010100, 1'b1};
        vecs[2] = '{B_START,   0, 24'h000101, 6'b000100, 1'b0};
        vecs[3] = '{3'b000,  100, 24'h000101, 6'b000100, 1'b0};
        vecs[4] = '{B_CLEAR,   0, 24'h000108, 6'b010100, 1'b1};
        vecs[5] = '{B_START,   0, 24'h000109, 6'b000100, 1'b0};
        vecs[6] = '{B_CLEAR | B_START, 0, 24'h000000, 6'b000100, 1'b0};
        vecs[7] = '{B_START, 136, 24'h000036, 6'b010100, 1'b1};
        vecs[8] = '{3'b000,  313, 24'h000037, 6'b010100, 1'b1};
        vecs[9] = '{B_START,   0, 24'h000124, 6'b000100, 1'b0};

        rst = 1'b0;
        set_btn(3'b000);
        step(2);
        check("reset", 24'h000000, 6'b000100, 1'b0);
        rst = 1'b1;
        step(2);

        // 2-cycle glitch must not be accepted
        btn_start = 1'b1;
        step(2);
        btn_start = 1'b0;
        step(14);
        check("glitch", 24'h000000, 6'b000100, 1'b0);

        // Press latency: running rises on the 7th edge after the raw edge
        btn_start = 1'b1;
        step(6);
        check("start_lat6", 24'h000000, 6'b000100, 1'b0);
        step(1);
        check("start_lat7", 24'h000000, 6'b010100, 1'b1);
        step(3);
        btn_start = 1'b0;
        step(6);
        check("start_done", 24'h000002, 6'b010100, 1'b1);

        run_vecs(0, 3);

        // Resume from pause with prescaler at 3: tick on the first running edge
        btn_start = 1'b1;
        step(7);
        check("resume_edge", 24'h000101, 6'b010100, 1'b1);
        step(1);
        check("resume_tick", 24'h000102, 6'b010100, 1'b1);
        step(2);
        btn_start = 1'b0;
        step(6);
        check("resume_done", 24'h000104, 6'b010100, 1'b1);

        run_vecs(4, 7);

        // Lap accepted on a tick edge: snapshot holds the pre-tick count
        btn_lap = 1'b1;
        step(6);
        check("lap_pre", 24'h000037, 6'b010100, 1'b1);
        step(1);
        check("lap_edge", 24'h000037, 6'b010100, 1'b1);
        step(3);
        btn_lap = 1'b0;
        step(6);
        check("lap_frozen", 24'h000037, 6'b010100, 1'b1);

        run_vecs(8, 8);

        // Second lap press returns to the live count
        btn_lap = 1'b1;
        step(6);
        check("unlap_pre", 24'h000037, 6'b010100, 1'b1);
        step(1);
        check("unlap_edge", 24'h000120, 6'b010100, 1'b1);
        step(3);
        btn_lap = 1'b0;
        step(6);
        check("unlap_live", 24'h000122, 6'b010100, 1'b1);

        run_vecs(9, 9);

        // Preload 59:59.99 while paused (prescaler is at 1)
        force dut.cnt_q = 24'h595999;
        step(2);
        release dut.cnt_q;
        step(1);
        check("preload", 24'h595999, 6'b000100, 1'b0);

        btn_start = 1'b1;
        step(9);
        check("pre_wrap", 24'h595999, 6'b000100, 1'b1);
        step(1);
`ifdef STOPWATCH_SATURATE_EN
        check("sat_edge", 24'h595999, 6'b000100, 1'b0);
`else
        check("wrap_edge", 24'h000000, 6'b010100, 1'b1);
`endif
        btn_start = 1'b0;
        step(6);
`ifdef STOPWATCH_SATURATE_EN
        check("sat_hold", 24'h595999, 6'b000100, 1'b0);
`else
        check("wrap_count", 24'h000001, 6'b010100, 1'b1);
`endif

        // Asynchronous reset mid-operation, then no counting afterwards
        rst = 1'b0;
        #2;
        check("async_rst", 24'h000000, 6'b000100, 1'b0);
        step(3);
        rst = 1'b1;
        step(20);
        check("post_rst", 24'h000000, 6'b000100, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
